// File: rtl/score_display_scan.sv
// score_display_scan: 4-digit multiplexed seven-segment driver for two BCD scores,
// with per-frame input latching, leading-zero blanking and whole-display blink.
module score_display_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_left,
  input  logic [11:0] bcd_right,
  input  logic        blank_lead,
  input  logic        flash,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic [PW-1:0] r_pre_cnt;
  logic [1:0]    r_idx;
  logic [11:0]   r_left, r_right;
  logic          r_blank, r_flash, r_hide;
  logic [BW-1:0] r_blink_cnt;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp, r_frame_tick;

  logic          w_tick, w_frame, w_wrap, w_blank, w_hide, w_hide_nxt;
  logic [1:0]    w_idx;
  logic [11:0]   w_left, w_right, w_side;
  logic [BW-1:0] w_cnt_nxt;
  logic [3:0]    w_nib;
  logic [6:0]    w_pat;

  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'd0: f_seg = 7'b1000000;
      4'd1: f_seg = 7'b1111001;
      4'd2: f_seg = 7'b0100100;
      4'd3: f_seg = 7'b0110000;
      4'd4: f_seg = 7'b0011001;
      4'd5: f_seg = 7'b0010010;
      4'd6: f_seg = 7'b0000010;
      4'd7: f_seg = 7'b1111000;
      4'd8: f_seg = 7'b0000000;
      4'd9: f_seg = 7'b0010000;
      default: f_seg = DASH;
    endcase
  endfunction

  assign w_tick  = r_pre_cnt == PW'(REFRESH_DIV - 1);
  assign w_frame = w_tick && r_idx == 2'd3;
  assign w_idx   = r_idx + 2'd1;
  // On a frame-start edge the digit-0 pattern is built from the values being latched
  assign w_left  = w_frame ? bcd_left   : r_left;
  assign w_right = w_frame ? bcd_right  : r_right;
  assign w_blank = w_frame ? blank_lead : r_blank;
  assign w_wrap     = r_blink_cnt == BW'(BLINK_FRAMES - 1);
  assign w_cnt_nxt  = (!flash || !r_flash || w_wrap) ? '0 : r_blink_cnt + BW'(1);
  assign w_hide_nxt = flash && r_flash && (r_hide ^ w_wrap);
  assign w_hide     = w_frame ? w_hide_nxt : r_hide;
  assign w_side = w_idx[1] ? w_left : w_right;
  assign w_nib  = w_idx[0] ? w_side[7:4] : w_side[3:0];
  assign w_pat  = (w_side[11:8] != 4'd0 || w_nib > 4'd9) ? DASH :
                  (w_idx[0] && w_blank && w_nib == 4'd0) ? BLANK : f_seg(w_nib);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt    <= '0;
      r_idx        <= 2'd3;
      r_left       <= '0;
      r_right      <= '0;
      r_blank      <= 1'b0;
      r_flash      <= 1'b0;
      r_blink_cnt  <= '0;
      r_hide       <= 1'b0;
      r_an         <= 4'b1111;
      r_seg        <= BLANK;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_pre_cnt    <= w_tick ? '0 : r_pre_cnt + PW'(1);
      r_frame_tick <= w_frame;
      if (w_tick) begin
        r_idx <= w_idx;
        r_an  <= w_hide ? 4'b1111 : ~(4'b0001 << w_idx);
        r_seg <= w_hide ? BLANK : w_pat;
        r_dp  <= w_hide || w_idx != 2'd2;
      end
      if (w_frame) begin
        r_left      <= bcd_left;
        r_right     <= bcd_right;
        r_blank     <= blank_lead;
        r_flash     <= flash;
        r_blink_cnt <= w_cnt_nxt;
        r_hide      <= w_hide_nxt;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;
endmodule
